// File: rtl/bcd_seg_mux.sv
// rtl/bcd_seg_mux.sv - two-digit multiplexed seven-segment driver for packed BCD
module bcd_seg_mux #(
    parameter int REFRESH_DIV  = 1000,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bcd_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_GAP0  = 2'd1,
        S_TENS  = 2'd2,
        S_GAP1  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [7:0]      r_pending;
    logic            r_pend_v;
    logic [7:0]      r_active;
    logic [7:0]      w_active_next;
    logic            w_frame_edge;
    logic [6:0]      r_seg;
    logic [1:0]      r_an;
    logic            r_err;
    logic [6:0]      w_seg_next;
    logic [1:0]      w_an_next;
    logic            w_err_next;

    // Segment pattern (g..a) for one nibble; non-BCD values show a dash.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    // The only edge where the displayed pair may change: leaving GAP1.
    assign w_frame_edge = (r_state == S_GAP1);

    // Pick the word shown for the next frame; a load on the frame edge bypasses the pending register.
    always_comb begin
        w_active_next = r_active;
        if (w_frame_edge) begin
            if (load) begin
                w_active_next = bcd_in;
            end else if (r_pend_v) begin
                w_active_next = r_pending;
            end
        end
    end

    // Capture loads (last one wins); the frame edge consumes whatever was pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= 8'h00;
            r_pend_v  <= 1'b0;
        end else begin
            if (load) begin
                r_pending <= bcd_in;
            end
            if (w_frame_edge) begin
                r_pend_v <= 1'b0;
            end else if (load) begin
                r_pend_v <= 1'b1;
            end
        end
    end

    // State, slot counter and displayed word advance together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_GAP1;
            r_cnt    <= '0;
            r_active <= 8'h00;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_active <= w_active_next;
        end
    end

    // Fixed frame sequence: UNITS (N cycles), GAP0, TENS (N cycles), GAP1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            S_UNITS: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_GAP0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_GAP0:  w_state_next = S_TENS;
            S_TENS: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_GAP1;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: w_state_next = S_UNITS;
        endcase
    end

    // Output values for the upcoming state, so the pins change on the same edge as the state.
    always_comb begin
        w_seg_next = 7'h00;
        w_an_next  = 2'b00;
        w_err_next = (w_active_next[7:4] > 4'd9) | (w_active_next[3:0] > 4'd9);
        case (w_state_next)
            S_UNITS: begin
                w_an_next  = 2'b01;
                w_seg_next = decode(w_active_next[3:0]);
            end
            S_TENS: begin
                if (!(blank_lz && (w_active_next[7:4] == 4'd0))) begin
                    w_an_next  = 2'b10;
                    w_seg_next = decode(w_active_next[7:4]);
                end
            end
            default: begin
                w_an_next  = 2'b00;
                w_seg_next = 7'h00;
            end
        endcase
    end

    // Registered outputs in logical polarity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= 7'h00;
            r_an  <= 2'b00;
            r_err <= 1'b0;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
            r_err <= w_err_next;
        end
    end

    assign seg = COMMON_ANODE ? ~r_seg : r_seg;
    assign an  = COMMON_ANODE ? ~r_an  : r_an;
    assign err = r_err;

endmodule
